// File: rtl/gate_tt_sequencer.sv
// Truth-table self-test sequencer for the two-input gate bank: drives a/b through 00..11, samples y_in, reports status.
// Optional: define GATE_TT_ABORT_ON_FAIL_EN to stop at the first mismatching vector.
module gate_tt_sequencer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] y_in,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [2:0] err_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

`ifdef GATE_TT_ABORT_ON_FAIL_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic [1:0] state;
  logic [3:0] cnt;
  logic [7:0] expected, diff, mask_nxt;
  logic       sample, last;

  // a and b are the two bits of the registered vector index
  assign a = vec_idx[1];
  assign b = vec_idx[0];

  assign expected = {~(a ^ b), a ^ b, a, ~a, ~(a | b), ~(a & b), a | b, a & b};
  assign diff     = y_in ^ expected;
  assign mask_nxt = fail_mask | diff;
  assign sample   = (state == S_DRIVE) && (cnt == HOLD_LAST);
  assign last     = (vec_idx == 2'd3) || (ABORT && (|diff));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            cnt       <= '0;
            vec_idx   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
          end
        end
        S_DRIVE: begin
          if (sample) begin
            fail_mask <= mask_nxt;
            if (|diff) err_count <= err_count + 3'd1;
            if (last) begin
              // pass reflects the mask including this final sample
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mask_nxt == 8'h00);
            end else begin
              vec_idx <= vec_idx + 2'd1;
              cnt     <= '0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: two instances (HOLD 2 and HOLD 1) against a run-level arithmetic model plus literal checks.
module tb_gate_tt_sequencer;

  typedef struct packed {
    logic       a, b;
    logic [1:0] vec;
    logic       busy, done, pass;
    logic [7:0] fm;
    logic [2:0] err;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] f0, iv;
  logic [7:0] y2, y1;
  out_t       act [2];
  int         nvec = 0, nmis = 0;
  bit         chk = 1'b0;

  always #5 clk = ~clk;

  gate_tt_sequencer #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y2),
    .a(act[0].a), .b(act[0].b), .vec_idx(act[0].vec), .busy(act[0].busy),
    .done(act[0].done), .pass(act[0].pass), .fail_mask(act[0].fm), .err_count(act[0].err));

  gate_tt_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y1),
    .a(act[1].a), .b(act[1].b), .vec_idx(act[1].vec), .busy(act[1].busy),
    .done(act[1].done), .pass(act[1].pass), .fail_mask(act[1].fm), .err_count(act[1].err));

  // Gate bank truth table, hand-derived per vector {a,b}: bits AND,OR,NAND,NOR,NOTA,BUFA,XOR,XNOR
  function automatic logic [7:0] tt(input int v);
    case (v)
      0: tt = 8'h9C;
      1: tt = 8'h56;
      2: tt = 8'h66;
      default: tt = 8'hA3;
    endcase
  endfunction

  function automatic logic [7:0] bank(input int v, input logic [7:0] force0, input logic [7:0] inv);
    bank = (tt(v) & ~force0) ^ inv;
  endfunction

  assign y2 = bank(int'({act[0].a, act[0].b}), f0, iv);
  assign y1 = bank(int'({act[1].a, act[1].b}), f0, iv);

  // Outputs k edges after an accepted start, from the count of completed samples
  function automatic out_t predict(input int h, input int k, input logic [7:0] force0, input logic [7:0] inv);
    out_t o;
    logic [7:0] d [4];
    int stop, n;
    stop = 4;
    for (int v = 0; v < 4; v++) begin
      d[v] = bank(v, force0, inv) ^ tt(v);
`ifdef GATE_TT_ABORT_ON_FAIL_EN
      if (stop == 4 && d[v] != 0) stop = v + 1;
`endif
    end
    n = k / h;
    o = '0;
    o.done = (n >= stop);
    if (o.done) n = stop;
    for (int v = 0; v < n; v++) begin
      o.fm = o.fm | d[v];
      if (d[v] != 0) o.err = o.err + 3'd1;
    end
    o.busy = ~o.done;
    o.vec  = 2'(o.done ? stop - 1 : n);
    o.a    = o.vec[1];
    o.b    = o.vec[0];
    o.pass = o.done && (o.fm == 8'h00);
    return o;
  endfunction

  bit         run [2];
  int         kk  [2];
  logic [7:0] f0l [2], ivl [2];
  localparam int HS [2] = '{2, 1};

  function automatic out_t model_out(input int d);
    if (!run[d]) return '0;
    return predict(HS[d], kk[d], f0l[d], ivl[d]);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) run[d] = 1'b0;
      else if (start && (!run[d] || model_out(d).done)) begin
        run[d] = 1'b1; kk[d] = 0; f0l[d] = f0; ivl[d] = iv;
      end else if (run[d]) kk[d] = kk[d] + 1;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      for (int d = 0; d < 2; d++) begin
        out_t e;
        e = model_out(d);
        nvec++;
        if (act[d] !== e) begin
          nmis++;
          $display("FAIL model dut%0d t=%0t: got %h expected %h", d, $time, act[d], e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  int cnt2, cnt1;

  // Pulse start, count busy cycles on both instances, return at first negedge with dut2 done
  task automatic run_seq();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt2 = 0; cnt1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (act[0].busy) cnt2++;
      if (act[1].busy) cnt1++;
      if (act[0].done) break;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; f0 = 8'h00; iv = 8'h00;
    @(posedge clk); @(negedge clk);
    chk = 1'b1;
    check("reset_busy", act[0].busy, 0);
    check("reset_fm", act[0].fm, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // correct bank
    run_seq();
    check("t1_busy_cycles_h2", cnt2, 8);
    check("t1_busy_cycles_h1", cnt1, 4);
    check("t1_pass", act[0].pass, 1);
    check("t1_fm", act[0].fm, 8'h00);
    check("t1_err", act[0].err, 0);
    check("t1_vec", act[0].vec, 3);
    check("t5_h1_pass", act[1].pass, 1);

    // XOR stuck at 0
    f0 = 8'h40;
    run_seq();
    check("t2_fm", act[0].fm, 8'h40);
    check("t2_err", act[0].err, 2);
    check("t2_pass", act[0].pass, 0);
    f0 = 8'h00;

    // AND inverted on every vector, then a clean rerun
    iv = 8'h01;
    run_seq();
    check("t3_fm", act[0].fm, 8'h01);
    check("t3_err", act[0].err, 4);
    check("t3_h1_err", act[1].err, 4);
    iv = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("t3_clear_fm", act[0].fm, 0);
    check("t3_clear_err", act[0].err, 0);
    check("t3_clear_done", act[0].done, 0);
    repeat (8) @(negedge clk);
    check("t3_rerun_pass", act[0].pass, 1);

    // start re-pulsed while busy is ignored
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_done_not_early", act[0].done, 0);
    @(negedge clk);
    check("t4_done_cycle8", act[0].done, 1);
    check("t4_h1_pass", act[1].pass, 1);

    // reset at cycle 5 of a run
    f0 = 8'h40;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_fm_before_rst", act[0].fm, 8'h40);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("t4_rst_busy", act[0].busy, 0);
    check("t4_rst_fm", act[0].fm, 0);
    check("t4_rst_vec", act[0].vec, 0);
    repeat (10) @(negedge clk);
    check("t4_rst_no_done", act[0].done, 0);
    f0 = 8'h00;

    // NOR stuck at 0: only vector 0 mismatches
    f0 = 8'h08;
    run_seq();
    check("t6_fm", act[0].fm, 8'h08);
    check("t6_err", act[0].err, 1);
    check("t6_pass", act[0].pass, 0);
`ifdef GATE_TT_ABORT_ON_FAIL_EN
    check("t6_vec", act[0].vec, 0);
    check("t6_busy_cycles", cnt2, 2);
`else
    check("t6_vec", act[0].vec, 3);
    check("t6_busy_cycles", cnt2, 8);
`endif
    f0 = 8'h00;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
